scan_decoder: RTL and testbench

- Parametrised, registered one-hot channel decoder with a built-in scan sequencer.
- Generalises the fixed 2-to-4 decoder to 2^SEL_WIDTH channels.
- Adds a prescaled auto-scan mode, a manual-select mode, per-channel skip mask, output polarity selection and dead-time blanking between steps.
- Drives multiplexed display digit enables (anodes) for the SD card readout display path.

---
 rtl/scan_decoder.sv | 111 +++++++++++
 tb/tb_scan_decoder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/scan_decoder.sv
// scan_decoder: registered one-hot (or one-cold) channel decoder with a
// prescaled auto-scan sequencer, manual channel select, per-channel skip
// mask, selectable output polarity and dead-time blanking between steps.
// Typical use: driving multiplexed display digit enables.
module scan_decoder #(
  parameter int SEL_WIDTH   = 2,
  parameter int PRESCALE    = 50000,
  parameter int DEAD_CYCLES = 0,
  parameter int ACTIVE_LOW  = 0
) (
  input  logic                      clock,
  input  logic                      resetN,
  input  logic                      enable,
  input  logic                      manualMode,
  input  logic [SEL_WIDTH-1:0]      selectIn,
  input  logic [(2**SEL_WIDTH)-1:0] channelMask,
  output logic [(2**SEL_WIDTH)-1:0] signalOut,
  output logic [SEL_WIDTH-1:0]      indexOut,
  output logic                      stepPulse
);

  localparam int N      = 2**SEL_WIDTH;
  localparam int PRE_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DEAD_W = (DEAD_CYCLES > 0) ? $clog2(DEAD_CYCLES + 1) : 1;

  localparam logic [PRE_W-1:0]  PRE_MAX   = PRE_W'(PRESCALE - 1);
  localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD_CYCLES);
  localparam logic [N-1:0]      INACTIVE  = (ACTIVE_LOW != 0) ? {N{1'b1}} : {N{1'b0}};

  logic [SEL_WIDTH-1:0] r_index;
  logic [PRE_W-1:0]     r_pre;
  logic [DEAD_W-1:0]    r_dead;
  logic [N-1:0]         r_signal;
  logic                 r_step;

  logic                 w_found;
  logic [SEL_WIDTH-1:0] w_searchIndex;
  logic                 w_tick;
  logic [SEL_WIDTH-1:0] w_nextIndex;
  logic [PRE_W-1:0]     w_nextPre;
  logic [DEAD_W-1:0]    w_nextDead;
  logic                 w_change;
  logic                 w_assert;
  logic [N-1:0]         w_onehot;
  logic [N-1:0]         w_nextSignal;

  // Circular search for the nearest enabled channel after the current one;
  // iterating from the far end lets the closest hit overwrite the others,
  // and offset N wraps back onto the current index itself.
  always_comb begin
    w_found       = 1'b0;
    w_searchIndex = r_index;
    for (int k = N; k >= 1; k--) begin
      if (channelMask[r_index + SEL_WIDTH'(k)]) begin
        w_found       = 1'b1;
        w_searchIndex = r_index + SEL_WIDTH'(k);
      end
    end
  end

  // Next-state logic: index, prescaler, dead counter and output pattern.
  always_comb begin
    w_tick      = (r_pre == PRE_MAX);
    w_nextIndex = r_index;
    w_nextPre   = r_pre;
    w_nextDead  = r_dead;
    w_change    = 1'b0;
    if (enable) begin
      if (manualMode) begin
        w_nextIndex = selectIn;
        w_nextPre   = '0;
      end else begin
        w_nextPre = w_tick ? '0 : r_pre + PRE_W'(1);
        if (w_tick && w_found) begin
          w_nextIndex = w_searchIndex;
        end
      end
      w_change = (w_nextIndex != r_index);
      if (w_change) begin
        w_nextDead = DEAD_LOAD;
      end else if (r_dead != '0) begin
        w_nextDead = r_dead - DEAD_W'(1);
      end
    end
    w_assert     = enable && channelMask[w_nextIndex] && (w_nextDead == '0);
    w_onehot     = N'(1) << w_nextIndex;
    w_nextSignal = w_assert ? (INACTIVE ^ w_onehot) : INACTIVE;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      r_index  <= '0;
      r_pre    <= '0;
      r_dead   <= '0;
      r_signal <= INACTIVE;
      r_step   <= 1'b0;
    end else begin
      r_index  <= w_nextIndex;
      r_pre    <= w_nextPre;
      r_dead   <= w_nextDead;
      r_signal <= w_nextSignal;
      r_step   <= w_change;
    end
  end

  assign signalOut = r_signal;
  assign indexOut  = r_index;
  assign stepPulse = r_step;

endmodule

// File: tb/tb_scan_decoder.sv
// tb_scan_decoder: three scan_decoder instances (plain 4-channel, 4-channel
// active-low with dead time, 8-channel fast scan) driven by a vector table,
// directed dead-time/scaling sequences and random stimulus, all compared
// against a behavioural model.
module tb_scan_decoder;

  typedef struct {
    logic       rstN;
    logic       en;
    logic       man;
    logic [1:0] sel;
    logic [3:0] mask;
    logic [3:0] expSig;
    logic [1:0] expIdx;
    logic       expStep;
  } vec_t;

  typedef struct {
    int         idx;
    int         pre;
    int         dead;
    logic [7:0] sig;
    logic       step;
  } mstate_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       resetN = 1'b0;
  logic       enable = 1'b1;
  logic       manualMode = 1'b0;
  logic [1:0] selectIn = '0;
  logic [3:0] channelMask = 4'hF;
  logic       enableC = 1'b1;
  logic       manualC = 1'b0;
  logic [2:0] selC = '0;
  logic [7:0] maskC = 8'hFF;

  logic [3:0] sigA, sigB;
  logic [1:0] idxA, idxB;
  logic       stepA, stepB;
  logic [7:0] sigC;
  logic [2:0] idxC;
  logic       stepC;

  int nAssert = 0;
  int nFail = 0;
  mstate_t mA, mB, mC;
  vec_t vecs[$];
  logic [3:0] expB [8];

  scan_decoder #(.SEL_WIDTH(2), .PRESCALE(4), .DEAD_CYCLES(0), .ACTIVE_LOW(0)) dutA (
    .clock(clock), .resetN(resetN), .enable(enable), .manualMode(manualMode),
    .selectIn(selectIn), .channelMask(channelMask),
    .signalOut(sigA), .indexOut(idxA), .stepPulse(stepA));

  scan_decoder #(.SEL_WIDTH(2), .PRESCALE(4), .DEAD_CYCLES(2), .ACTIVE_LOW(1)) dutB (
    .clock(clock), .resetN(resetN), .enable(enable), .manualMode(manualMode),
    .selectIn(selectIn), .channelMask(channelMask),
    .signalOut(sigB), .indexOut(idxB), .stepPulse(stepB));

  scan_decoder #(.SEL_WIDTH(3), .PRESCALE(2), .DEAD_CYCLES(1), .ACTIVE_LOW(0)) dutC (
    .clock(clock), .resetN(resetN), .enable(enableC), .manualMode(manualC),
    .selectIn(selC), .channelMask(maskC),
    .signalOut(sigC), .indexOut(idxC), .stepPulse(stepC));

  // Behavioural model: one clock of the decoder described by its rules.
  function automatic mstate_t modelStep(input mstate_t s, input int n, input int prescale,
                                        input int deadCycles, input int activeLow,
                                        input logic rstN, input logic en, input logic man,
                                        input int sel, input logic [7:0] mask);
    mstate_t    r;
    logic [7:0] inactive;
    int         newIdx;
    logic       found;
    r = s;
    inactive = (activeLow != 0) ? 8'((1 << n) - 1) : 8'd0;
    if (!rstN) begin
      r.idx = 0; r.pre = 0; r.dead = 0; r.step = 1'b0; r.sig = inactive;
      return r;
    end
    if (!en) begin
      r.step = 1'b0; r.sig = inactive;
      return r;
    end
    newIdx = s.idx;
    if (man) begin
      newIdx = sel;
      r.pre = 0;
    end else if (s.pre == prescale - 1) begin
      r.pre = 0;
      found = 1'b0;
      for (int k = 1; k <= n; k++) begin
        if (!found && mask[(s.idx + k) % n]) begin
          found = 1'b1;
          newIdx = (s.idx + k) % n;
        end
      end
    end else begin
      r.pre = s.pre + 1;
    end
    r.step = (newIdx != s.idx);
    r.idx = newIdx;
    if (r.step) r.dead = deadCycles;
    else if (s.dead > 0) r.dead = s.dead - 1;
    r.sig = inactive;
    if (r.dead == 0 && mask[newIdx]) r.sig[newIdx] = (activeLow == 0);
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    nAssert++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
    end
  endtask

  // Advance one clock, step all models and compare every output.
  task automatic advance();
    @(posedge clock);
    #1;
    mA = modelStep(mA, 4, 4, 0, 0, resetN, enable, manualMode, int'(selectIn), {4'b0, channelMask});
    mB = modelStep(mB, 4, 4, 2, 1, resetN, enable, manualMode, int'(selectIn), {4'b0, channelMask});
    mC = modelStep(mC, 8, 2, 1, 0, resetN, enableC, manualC, int'(selC), maskC);
    checkOutput("modelSigA", {4'b0, sigA}, mA.sig);
    checkOutput("modelIdxA", {6'b0, idxA}, 8'(mA.idx));
    checkOutput("modelStepA", {7'b0, stepA}, {7'b0, mA.step});
    checkOutput("modelSigB", {4'b0, sigB}, mB.sig);
    checkOutput("modelIdxB", {6'b0, idxB}, 8'(mB.idx));
    checkOutput("modelStepB", {7'b0, stepB}, {7'b0, mB.step});
    checkOutput("modelSigC", sigC, mC.sig);
    checkOutput("modelIdxC", {5'b0, idxC}, 8'(mC.idx));
    checkOutput("modelStepC", {7'b0, stepC}, {7'b0, mC.step});
    checkOutput("onehotA", 8'($onehot0(sigA)), 8'd1);
    checkOutput("onehotB", 8'($onehot0(sigB ^ 4'hF)), 8'd1);
    checkOutput("onehotC", 8'($onehot0(sigC)), 8'd1);
  endtask

  task automatic applyStimulus(input vec_t v);
    resetN      = v.rstN;
    enable      = v.en;
    manualMode  = v.man;
    selectIn    = v.sel;
    channelMask = v.mask;
    enableC     = v.en;
    manualC     = v.man;
    selC        = {1'b0, v.sel};
    maskC       = 8'hFF;
  endtask

  task automatic addVec(input int count, input logic rstN, input logic en, input logic man,
                        input logic [1:0] sel, input logic [3:0] mask,
                        input logic [3:0] expSig, input logic [1:0] expIdx, input logic expStep);
    vec_t v;
    v.rstN = rstN; v.en = en; v.man = man; v.sel = sel; v.mask = mask;
    v.expSig = expSig; v.expIdx = expIdx; v.expStep = expStep;
    for (int i = 0; i < count; i++) vecs.push_back(v);
  endtask

  initial begin
    mA = '{0, 0, 0, 8'h00, 1'b0};
    mB = '{0, 0, 0, 8'h0F, 1'b0};
    mC = '{0, 0, 0, 8'h00, 1'b0};

    // Reset, then a full auto walk 0,1,2,3,0 with 4-cycle dwell.
    addVec(3, 1'b0, 1'b1, 1'b0, 2'd0, 4'hF, 4'h0, 2'd0, 1'b0);
    for (int s = 0; s < 4; s++) begin
      addVec(3, 1'b1, 1'b1, 1'b0, 2'd0, 4'hF, 4'(1 << s), 2'(s), 1'b0);
      addVec(1, 1'b1, 1'b1, 1'b0, 2'd0, 4'hF, 4'(1 << ((s + 1) % 4)), 2'((s + 1) % 4), 1'b1);
    end
    // Mask skip 1,3,1,3 then an empty mask freezing the index.
    addVec(3, 1'b1, 1'b1, 1'b0, 2'd0, 4'hA, 4'h0, 2'd0, 1'b0);
    addVec(1, 1'b1, 1'b1, 1'b0, 2'd0, 4'hA, 4'h2, 2'd1, 1'b1);
    addVec(3, 1'b1, 1'b1, 1'b0, 2'd0, 4'hA, 4'h2, 2'd1, 1'b0);
    addVec(1, 1'b1, 1'b1, 1'b0, 2'd0, 4'hA, 4'h8, 2'd3, 1'b1);
    addVec(3, 1'b1, 1'b1, 1'b0, 2'd0, 4'hA, 4'h8, 2'd3, 1'b0);
    addVec(1, 1'b1, 1'b1, 1'b0, 2'd0, 4'hA, 4'h2, 2'd1, 1'b1);
    addVec(3, 1'b1, 1'b1, 1'b0, 2'd0, 4'hA, 4'h2, 2'd1, 1'b0);
    addVec(1, 1'b1, 1'b1, 1'b0, 2'd0, 4'hA, 4'h8, 2'd3, 1'b1);
    addVec(6, 1'b1, 1'b1, 1'b0, 2'd0, 4'h0, 4'h0, 2'd3, 1'b0);
    // Manual select, repeat, masked current channel, new select.
    addVec(1, 1'b1, 1'b1, 1'b1, 2'd2, 4'hF, 4'h4, 2'd2, 1'b1);
    addVec(2, 1'b1, 1'b1, 1'b1, 2'd2, 4'hF, 4'h4, 2'd2, 1'b0);
    addVec(1, 1'b1, 1'b1, 1'b1, 2'd2, 4'hB, 4'h0, 2'd2, 1'b0);
    addVec(1, 1'b1, 1'b1, 1'b1, 2'd1, 4'hB, 4'h2, 2'd1, 1'b1);
    // Back to auto, enable dropped at prescaler 2, resume, reset on a tick.
    addVec(2, 1'b1, 1'b1, 1'b0, 2'd0, 4'hF, 4'h2, 2'd1, 1'b0);
    addVec(5, 1'b1, 1'b0, 1'b0, 2'd0, 4'hF, 4'h0, 2'd1, 1'b0);
    addVec(1, 1'b1, 1'b1, 1'b0, 2'd0, 4'hF, 4'h2, 2'd1, 1'b0);
    addVec(1, 1'b1, 1'b1, 1'b0, 2'd0, 4'hF, 4'h4, 2'd2, 1'b1);
    addVec(3, 1'b1, 1'b1, 1'b0, 2'd0, 4'hF, 4'h4, 2'd2, 1'b0);
    addVec(1, 1'b0, 1'b1, 1'b0, 2'd0, 4'hF, 4'h0, 2'd0, 1'b0);
    addVec(1, 1'b1, 1'b1, 1'b0, 2'd0, 4'hF, 4'h1, 2'd0, 1'b0);

    $display("[TB] applying %0d table vectors", vecs.size());
    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      advance();
      checkOutput("tableSig", {4'b0, sigA}, {4'b0, vecs[i].expSig});
      checkOutput("tableIdx", {6'b0, idxA}, {6'b0, vecs[i].expIdx});
      checkOutput("tableStep", {7'b0, stepA}, {7'b0, vecs[i].expStep});
    end

    // Dead-time blanking on the active-low instance and the 8-channel walk.
    $display("[TB] dead-time and scaling sequence");
    expB = '{4'hE, 4'hE, 4'hE, 4'hF, 4'hF, 4'hD, 4'hD, 4'hF};
    resetN = 1'b0; enable = 1'b1; manualMode = 1'b0; channelMask = 4'hF;
    enableC = 1'b1; manualC = 1'b0; maskC = 8'hFF; selC = '0;
    repeat (2) advance();
    resetN = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      advance();
      if (c <= 8) checkOutput("deadTimeB", {4'b0, sigB}, {4'b0, expB[c-1]});
      if (c % 2 == 0) checkOutput("walkC", {5'b0, idxC}, 8'((c / 2) % 8));
    end

    // Randomised traffic against the model.
    $display("[TB] random phase");
    for (int i = 0; i < 3000; i++) begin
      resetN = ($urandom_range(0, 63) != 0);
      enable = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 15) == 0) manualMode = ~manualMode;
      if ($urandom_range(0, 3) == 0) selectIn = 2'($urandom);
      if ($urandom_range(0, 7) == 0) channelMask = 4'($urandom);
      enableC = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 15) == 0) manualC = ~manualC;
      if ($urandom_range(0, 3) == 0) selC = 3'($urandom);
      if ($urandom_range(0, 7) == 0) maskC = 8'($urandom);
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
